// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder behind the MEM-stage
// load/store interface. A request (MemRead/MemWrite) is latched in IDLE,
// Stall holds the pipeline for LATENCY further cycles, then a one-cycle
// Done (or AddrError) pulse returns the extended load data. Stores are
// byte/half/word masked via an internal read-modify-write.
//
// Ports:
//   Clk, Rst           clock (rising edge), async active-low reset
//   MemRead/MemWrite   request strobes, held until Done/AddrError
//   Address            byte address
//   WriteData          right-aligned store data
//   Bytes2Store/Load   size: 00 word, 01 half, 10 byte, 11 word
//   LoadSigned         sign-extend sub-word loads
//   ReadData           load result, valid with Done
//   Stall              request pending
//   Done / AddrError   completion / fault pulse (mutually exclusive)
//   DisplayData        MMIO display register
//
// Optional feature macro: DMEM_MMIO_EN (word-accessible display register at
// MMIO_ADDR). Without it DisplayData is 0 and MMIO_ADDR faults.
module dmem_responder #(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Bytes2Store,
    input  logic [1:0]  Bytes2Load,
    input  logic        LoadSigned,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        AddrError,
    output logic [31:0] DisplayData
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        aerr_q, aerr_d;
    logic [31:0] disp_q, disp_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          is_word, mmio_hit, in_range, fault, mem_we;
    logic [31:0]   mem_word, src_word, load_val, merge_word;
    logic [15:0]   half_v;
    logic [7:0]    byte_v;

    assign idx      = addr_q[AW+1:2];
    assign is_word  = (size_q == 2'b00) || (size_q == 2'b11);
    assign mmio_hit = (addr_q[31:2] == MMIO_ADDR[31:2]);
    assign in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
    assign mem_word = mem_q[idx];

    always_comb begin
        fault = (is_word && (addr_q[1:0] != 2'b00)) || ((size_q == 2'b01) && addr_q[0]);
`ifdef DMEM_MMIO_EN
        // The display register lives outside the array and is word-only.
        fault = fault || (mmio_hit ? !is_word : !in_range);
        src_word = mmio_hit ? disp_q : mem_word;
`else
        fault = fault || !in_range || mmio_hit;
        src_word = mem_word;
`endif
    end

    // Load lane select and extension (little-endian).
    always_comb begin
        half_v   = addr_q[1] ? src_word[31:16] : src_word[15:0];
        byte_v   = src_word[8*addr_q[1:0] +: 8];
        load_val = src_word;
        case (size_q)
            2'b01:   load_val = sign_q ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            2'b10:   load_val = sign_q ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            default: load_val = src_word;
        endcase
    end

    // Store merge: untouched bytes keep their current array contents.
    always_comb begin
        merge_word = wdata_q;
        case (size_q)
            2'b01: merge_word = addr_q[1] ? {wdata_q[15:0], mem_word[15:0]}
                                          : {mem_word[31:16], wdata_q[15:0]};
            2'b10: begin
                merge_word = mem_word;
                merge_word[8*addr_q[1:0] +: 8] = wdata_q[7:0];
            end
            default: merge_word = wdata_q;
        endcase
    end

    // Commit happens on the edge leaving RESP; an async reset forces IDLE
    // first, so an abandoned store never reaches the array.
    assign mem_we = (state_q == S_RESP) && wr_q && done_q && !mmio_hit;

    always_ff @(posedge Clk) begin
        if (mem_we) mem_q[idx] <= merge_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wr_d    = wr_q;
        rdata_d = 32'b0;
        done_d  = 1'b0;
        aerr_d  = 1'b0;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = Address;
                    wdata_d = WriteData;
                    // Read+write together is treated as a store.
                    size_d  = MemWrite ? Bytes2Store : Bytes2Load;
                    sign_d  = LoadSigned;
                    wr_d    = MemWrite;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    aerr_d  = fault;
                    done_d  = !fault;
                    rdata_d = (fault || wr_q) ? 32'b0 : load_val;
`ifdef DMEM_MMIO_EN
                    if (wr_q && mmio_hit && !fault) disp_d = wdata_q;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'b0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            disp_q  <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            aerr_q  <= aerr_d;
            disp_q  <= disp_d;
        end
    end

    // Stall is combinational so the request cycle itself is held; gated by
    // reset so it reads 0 while Rst is low.
    assign Stall     = Rst && ((state_q == S_WAIT) ||
                               ((state_q == S_IDLE) && (MemRead || MemWrite)));
    assign ReadData  = rdata_q;
    assign Done      = done_q;
    assign AddrError = aerr_q;
`ifdef DMEM_MMIO_EN
    assign DisplayData = disp_q;
`else
    assign DisplayData = 32'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, LoadSigned = 1'b0;
    logic [31:0] Address = '0, WriteData = '0;
    logic [1:0]  Bytes2Store = '0, Bytes2Load = '0;
    logic [31:0] ReadData, DisplayData;
    logic        Stall, Done, AddrError;

    dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(1024), .MMIO_ADDR(32'hFFFF0000)) dut (
        .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .Bytes2Store(Bytes2Store),
        .Bytes2Load(Bytes2Load), .LoadSigned(LoadSigned), .ReadData(ReadData),
        .Stall(Stall), .Done(Done), .AddrError(AddrError), .DisplayData(DisplayData)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        done;
        logic        aerr;
        logic [31:0] rdata;
        logic [31:0] disp;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          req_id = 0;
    logic [31:0] exp_disp = '0;

    // Monitor: every completion pulse is checked against the oldest expectation.
    always @(negedge Clk) begin
        if (Rst && (Done || AddrError)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: Done=%0b AddrError=%0b with no request outstanding", Done, AddrError);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({Done, AddrError} !== {e.done, e.aerr}) begin
                    bad++;
                    $display("FAIL req%0d_status: got Done=%0b AddrError=%0b want Done=%0b AddrError=%0b",
                             e.id, Done, AddrError, e.done, e.aerr);
                end
                total++;
                if (ReadData !== e.rdata) begin
                    bad++;
                    $display("FAIL req%0d_rdata: got %h want %h", e.id, ReadData, e.rdata);
                end
                total++;
                if (DisplayData !== e.disp) begin
                    bad++;
                    $display("FAIL req%0d_disp: got %h want %h", e.id, DisplayData, e.disp);
                end
            end
        end
    end

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg,
                       input logic ed, input logic ea, input logic [31:0] er);
        exp_t e;
        int   n, stall_n;
        logic seen;
        @(posedge Clk); #1;
        MemRead = rd; MemWrite = wr; Address = a; WriteData = wd;
        Bytes2Store = sz; Bytes2Load = sz; LoadSigned = sg;
        e.done = ed; e.aerr = ea; e.rdata = er; e.disp = exp_disp; e.id = req_id;
        sb_q.push_back(e);
        n = 0; stall_n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge Clk);
            if (Done || AddrError) seen = 1'b1;
            else if (Stall) stall_n++;
            n++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL req%0d_timeout: no Done/AddrError within %0d cycles", req_id, n);
        end
        total++;
        if (stall_n != LAT + 1) begin
            bad++;
            $display("FAIL req%0d_stall_cycles: got %0d want %0d", req_id, stall_n, LAT + 1);
        end
        req_id++;
        @(posedge Clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if ({ReadData, Stall, Done, AddrError, DisplayData} !== '0) begin
            bad++;
            $display("FAIL reset_outs: rd=%h st=%0b dn=%0b ae=%0b disp=%h want all 0",
                     ReadData, Stall, Done, AddrError, DisplayData);
        end
        @(negedge Clk); Rst = 1'b1;

        //   rd    wr    addr          wdata         sz     sg    done  aerr  rdata
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        req(1'b0, 1'b1, 32'h10, 32'h11223344, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h12, 32'h123456AA, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h11AA3344);
        // Half at 0x12 is 0x11AA: positive, so both extensions agree.
        req(1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 1'b1, 1'b0, 32'h000011AA);
        req(1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0, 32'h000011AA);
        req(1'b1, 1'b0, 32'h12, 32'h0,        2'b10, 1'b1, 1'b1, 1'b0, 32'hFFFFFFAA);
        req(1'b1, 1'b0, 32'h12, 32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 32'h000000AA);
        req(1'b1, 1'b0, 32'h11, 32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 32'h00000033);
        req(1'b1, 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h13, 32'h0000FFFF, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        req(1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h11AA3344);
        req(1'b0, 1'b1, 32'h12, 32'h0000BEEF, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'hBEEF3344);
        req(1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 1'b1, 1'b0, 32'hFFFFBEEF);
        req(1'b1, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 1'b1, 1'b0, 32'h00003344);
        req(1'b1, 1'b0, 32'h1000, 32'h0,      2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        req(1'b1, 1'b0, 32'hFFC, 32'h0,       2'b00, 1'b0, 1'b1, 1'b0, 32'hx);
        req(1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'hFFC, 32'h0,       2'b00, 1'b0, 1'b1, 1'b0, 32'h0BADF00D);
        // Read and write together: store wins, ReadData stays 0.
        req(1'b1, 1'b1, 32'h20, 32'h00000055, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h00000055);

        // Reset in the middle of a store: abandoned, nothing committed.
        @(posedge Clk); #1;
        MemWrite = 1'b1; Address = 32'h10; WriteData = 32'hCAFEF00D; Bytes2Store = 2'b00;
        @(negedge Clk);
        total++;
        if (Stall !== 1'b1) begin
            bad++;
            $display("FAIL abort_req_stall: got %0b want 1", Stall);
        end
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        total++;
        if ({ReadData, Stall, Done, AddrError, DisplayData} !== '0) begin
            bad++;
            $display("FAIL abort_reset_outs: rd=%h st=%0b dn=%0b ae=%0b disp=%h want all 0",
                     ReadData, Stall, Done, AddrError, DisplayData);
        end
        MemWrite = 1'b0;
        exp_disp = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk); Rst = 1'b1;
        req(1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'hBEEF3344);

`ifdef DMEM_MMIO_EN
        exp_disp = 32'h00001234;
        req(1'b0, 1'b1, 32'hFFFF0000, 32'h00001234, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'hFFFF0000, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h00001234);
        req(1'b0, 1'b1, 32'hFFFF0000, 32'h000000FF, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
`else
        req(1'b0, 1'b1, 32'hFFFF0000, 32'h00001234, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        req(1'b1, 1'b0, 32'hFFFF0000, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
`endif

        repeat (4) @(posedge Clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
